// File: rtl/nibble_add_tester.sv
// Self-test initiator for a registered nibble adder: sweeps operand pairs, checks each
// returned sum against an internal model and reports pass/fail, error count and first failure.
module nibble_add_tester #(
    parameter int VECTORS = 256,
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] operand_out,
    input  logic [7:0] sum_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] first_fail,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] LAST_OPERAND = 8'(VECTORS - 1);
    localparam logic [1:0] LAST_DRAIN   = 2'(LATENCY - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] operand_q, operand_d;
    logic [1:0] drain_q, drain_d;
    logic [7:0] err_q, err_d;
    logic [7:0] ff_q, ff_d;
    logic       has_fail_q, has_fail_d;
    logic       clear;
    logic       mismatch;

    // Expected-value pipeline, aligned so the last stage lines up with sum_in.
    logic       valid_q [LATENCY];
    logic [7:0] exp_q   [LATENCY];
    logic [7:0] opnd_q  [LATENCY];

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        drain_d   = drain_q;
        clear     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = DRIVE;
                    operand_d = 8'h00;
                    drain_d   = 2'd0;
                    clear     = 1'b1;
                end
            end
            DRIVE: begin
                if (operand_q == LAST_OPERAND) begin
                    state_d   = DRAIN;
                    operand_d = 8'h00;
                end else begin
                    operand_d = operand_q + 8'd1;
                end
            end
            default: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = DONE;
                    drain_d = 2'd0;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
        endcase
    end

    // Upper nibble of sum_in must be zero, so any nonzero bit there is a mismatch too.
    assign mismatch = valid_q[LATENCY-1] && (sum_in != exp_q[LATENCY-1]);

    always_comb begin
        err_d      = err_q;
        ff_d       = ff_q;
        has_fail_d = has_fail_q;
        if (clear) begin
            err_d      = 8'h00;
            ff_d       = 8'h00;
            has_fail_d = 1'b0;
        end else if (mismatch) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (!has_fail_q) begin
                ff_d       = opnd_q[LATENCY-1];
                has_fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            operand_q  <= 8'h00;
            drain_q    <= 2'd0;
            err_q      <= 8'h00;
            ff_q       <= 8'h00;
            has_fail_q <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                exp_q[i]   <= 8'h00;
                opnd_q[i]  <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            operand_q  <= operand_d;
            drain_q    <= drain_d;
            err_q      <= err_d;
            ff_q       <= ff_d;
            has_fail_q <= has_fail_d;
            valid_q[0] <= (state_q == DRIVE);
            exp_q[0]   <= {4'h0, 4'(operand_q[7:4] + operand_q[3:0])};
            opnd_q[0]  <= operand_q;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                exp_q[i]   <= exp_q[i-1];
                opnd_q[i]  <= opnd_q[i-1];
            end
        end
    end

    assign operand_out = operand_q;
    assign busy        = (state_q == DRIVE) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign pass        = done && (err_q == 8'h00);
    assign err_count   = err_q;
    assign first_fail  = ff_q;
    assign state_dbg   = state_q;

endmodule
